// File: rtl/fft_pkg.sv
// Shared constants and select encodings for the 16-point radix-4 FFT core.
package fft_pkg;
  localparam int DW       = 16;
  localparam int N_PT     = 16;
  localparam int GRP_N    = 4;
  localparam int FLAG_CNT = 13;
  localparam int AW       = $clog2(N_PT);

  typedef enum logic [1:0] {
    S_P_SEL_0 = 2'd0,
    S_P_SEL_1 = 2'd1,
    S_P_SEL_2 = 2'd2,
    S_P_SEL_3 = 2'd3
  } s_p_sel_e;

  typedef enum logic [1:0] {
    REG_SEL_0 = 2'd0,
    REG_SEL_1 = 2'd1,
    REG_SEL_2 = 2'd2,
    REG_SEL_3 = 2'd3
  } reg_sel_e;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } cplx_t;

  // Radix-4 group g, lane j lives at sample index 4*j + g.
  function automatic logic [AW-1:0] grp_addr(input logic [1:0] lane, input logic [1:0] grp);
    return {lane, grp};
  endfunction
endpackage

// File: rtl/sp_bank.sv
// One 16-entry complex sample bank: single write port, combinational 4-lane group read.
module sp_bank
  import fft_pkg::*;
(
  input  logic                   clk,
  input  logic                   i_we,
  input  logic [AW-1:0]          i_waddr,
  input  cplx_t                  i_wdata,
  input  logic [1:0]             i_grp_sel,
  output cplx_t [GRP_N-1:0]      o_lane
);
  cplx_t r_mem [N_PT];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  generate
    for (genvar gi = 0; gi < GRP_N; gi++) begin : g_lane
      assign o_lane[gi] = r_mem[grp_addr(2'(gi), i_grp_sel)];
    end
  endgenerate
endmodule

// File: rtl/fft_s_p.sv
// Serial-to-parallel ping-pong input buffer for the 16-point radix-4 FFT.
// Optional SP_SOF_SYNC_EN adds in_sof to resynchronise the frame to index 0.
module fft_s_p
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_re,
  input  logic [DW-1:0]     in_im,
`ifdef SP_SOF_SYNC_EN
  input  logic              in_sof,
`endif
  input  logic [1:0]        grp_sel,
  output logic              s_p_flag,
  output logic [4*DW-1:0]   out_re,
  output logic [4*DW-1:0]   out_im
);
  logic [AW-1:0]    r_wr_cnt;
  logic             r_wr_bank;
  logic             r_rd_bank;
  logic             r_flag;
  logic [4*DW-1:0]  r_out_re;
  logic [4*DW-1:0]  r_out_im;

  logic             w_sof;
  logic [AW-1:0]    w_waddr;
  logic             w_at_flag;
  cplx_t            w_wdata;
  cplx_t [GRP_N-1:0] w_lane0;
  cplx_t [GRP_N-1:0] w_lane1;
  logic [4*DW-1:0]  w_out_re;
  logic [4*DW-1:0]  w_out_im;

`ifdef SP_SOF_SYNC_EN
  assign w_sof = in_valid & in_sof;
`else
  assign w_sof = 1'b0;
`endif

  assign w_waddr   = w_sof ? '0 : r_wr_cnt;
  assign w_at_flag = in_valid && (w_waddr == AW'(FLAG_CNT - 1));
  assign w_wdata   = '{re: in_re, im: in_im};

  sp_bank u_bank0 (
    .clk       (clk),
    .i_we      (in_valid & ~r_wr_bank),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_grp_sel (grp_sel),
    .o_lane    (w_lane0)
  );

  sp_bank u_bank1 (
    .clk       (clk),
    .i_we      (in_valid & r_wr_bank),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_grp_sel (grp_sel),
    .o_lane    (w_lane1)
  );

  generate
    for (genvar gi = 0; gi < GRP_N; gi++) begin : g_mux
      assign w_out_re[gi*DW +: DW] = r_rd_bank ? w_lane1[gi].re : w_lane0[gi].re;
      assign w_out_im[gi*DW +: DW] = r_rd_bank ? w_lane1[gi].im : w_lane0[gi].im;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_flag    <= 1'b0;
      r_out_re  <= '0;
      r_out_im  <= '0;
    end else begin
      // Flag keys on the write itself, so stalls at index 13 cannot re-fire it.
      r_flag   <= w_at_flag;
      r_out_re <= w_out_re;
      r_out_im <= w_out_im;
      if (w_at_flag) begin
        r_rd_bank <= r_wr_bank;
      end
      if (in_valid) begin
        if (w_sof) begin
          r_wr_cnt <= AW'(1);
        end else begin
          r_wr_cnt <= r_wr_cnt + 1'b1;
          if (r_wr_cnt == '1) begin
            r_wr_bank <= ~r_wr_bank;
          end
        end
      end
    end
  end

  assign s_p_flag = r_flag;
  assign out_re   = r_out_re;
  assign out_im   = r_out_im;
endmodule

// File: tb/tb_fft_s_p.sv
// Self-checking bench for fft_s_p: behavioural store model feeds a per-cycle scoreboard.
module tb_fft_s_p;
  import fft_pkg::*;

`ifdef SP_SOF_SYNC_EN
  localparam bit SOF_ON = 1'b1;
`else
  localparam bit SOF_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DW-1:0]     in_re;
  logic [DW-1:0]     in_im;
`ifdef SP_SOF_SYNC_EN
  logic              in_sof;
`endif
  logic [1:0]        grp_sel;
  logic              s_p_flag;
  logic [4*DW-1:0]   out_re;
  logic [4*DW-1:0]   out_im;

  always #5 clk = ~clk;

  fft_s_p dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_re    (in_re),
    .in_im    (in_im),
`ifdef SP_SOF_SYNC_EN
    .in_sof   (in_sof),
`endif
    .grp_sel  (grp_sel),
    .s_p_flag (s_p_flag),
    .out_re   (out_re),
    .out_im   (out_im)
  );

  typedef struct {
    bit              flag;
    bit              chk;
    logic [4*DW-1:0] re;
    logic [4*DW-1:0] im;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] m_re [2][16];
  logic [DW-1:0] m_im [2][16];
  bit            m_ok [2][16];
  int            m_cnt = 0;
  int            m_bank = 0;
  int            m_rd = 0;
  int            n_chk = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            flag_cyc[$];

  task automatic check(input string tag, input logic [4*DW-1:0] got, input logic [4*DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [4*DW-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [DW-1:0] t0, t1, t2, t3;
    t0 = DW'(a); t1 = DW'(b); t2 = DW'(c); t3 = DW'(d);
    return {t3, t2, t1, t0};
  endfunction

  // One clock: apply inputs, predict the post-edge outputs, then compare.
  task automatic drive(input bit r, input bit v, input bit sof, input int re, input int im, input int sel);
    exp_t e;
    int   idx;
    rst      = r;
    in_valid = v;
    in_re    = DW'(re);
    in_im    = DW'(im);
    grp_sel  = 2'(sel);
`ifdef SP_SOF_SYNC_EN
    in_sof   = sof;
`endif
    e.flag = 1'b0;
    e.chk  = 1'b1;
    e.re   = '0;
    e.im   = '0;
    if (r) begin
      m_cnt = 0; m_bank = 0; m_rd = 0;
    end else begin
      for (int j = 0; j < GRP_N; j++) begin
        if (!m_ok[m_rd][4*j+sel]) e.chk = 1'b0;
        e.re[j*DW +: DW] = m_re[m_rd][4*j+sel];
        e.im[j*DW +: DW] = m_im[m_rd][4*j+sel];
      end
      if (v) begin
        idx = (SOF_ON && sof) ? 0 : m_cnt;
        m_re[m_bank][idx] = DW'(re);
        m_im[m_bank][idx] = DW'(im);
        m_ok[m_bank][idx] = 1'b1;
        if (idx == FLAG_CNT - 1) begin
          e.flag = 1'b1;
          m_rd   = m_bank;
        end
        if (SOF_ON && sof) begin
          m_cnt = 1;
        end else begin
          if (m_cnt == 15) m_bank ^= 1;
          m_cnt = (m_cnt + 1) % 16;
        end
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    e = sb.pop_front();
    check("flag", {63'd0, s_p_flag}, {63'd0, e.flag});
    if (e.chk) begin
      check("out_re", out_re, e.re);
      check("out_im", out_im, e.im);
    end
    if (s_p_flag === 1'b1) flag_cyc.push_back(cyc);
    $display("cyc %0d rst %0b v %0b re %0d sel %0d -> flag %0b out_re %h out_im %h",
             cyc, r, v, re, sel, s_p_flag, out_re, out_im);
  endtask

  initial begin
    int nflag;
    rst = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0; grp_sel = '0;
`ifdef SP_SOF_SYNC_EN
    in_sof = 1'b0;
`endif
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 16; i++) m_ok[b][i] = 1'b0;

    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    check("reset_re", out_re, '0);

    // Frame A: re=k, im=-k into bank 0
    for (int k = 0; k < 16; k++) begin
      drive(0, 1, 0, k, -k, (k <= 13) ? 0 : k - 13);
      if (k == 13) begin
        check("A_g0_re", out_re, pack4(0, 4, 8, 12));
        check("A_g0_im", out_im, pack4(0, -4, -8, -12));
      end
      if (k == 14) check("A_g1_re", out_re, pack4(1, 5, 9, 13));
      if (k == 15) check("A_g2_re", out_re, pack4(2, 6, 10, 14));
    end

    // Frame B back-to-back into bank 1
    for (int k = 0; k < 16; k++) begin
      drive(0, 1, 0, 100 + k, -(100 + k), (k == 0) ? 3 : 0);
      if (k == 0) begin
        check("A_g3_re", out_re, pack4(3, 7, 11, 15));
        check("A_g3_im", out_im, pack4(-3, -7, -11, -15));
      end
      if (k == 13) check("B_g0_re", out_re, pack4(100, 104, 108, 112));
    end
    if (flag_cyc.size() >= 2) check("flag_gap", 64'(flag_cyc[1] - flag_cyc[0]), 64'd16);
    else check("flag_count_AB", 64'(flag_cyc.size()), 64'd2);

    // Frame C: valid gap of 5 cycles right after k=12
    nflag = flag_cyc.size();
    for (int k = 0; k < 13; k++) drive(0, 1, 0, 200 + k, -(200 + k), 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 0);
    check("C_gap_g0", out_re, pack4(200, 204, 208, 212));
    drive(0, 1, 0, 213, -213, 0);
    drive(0, 1, 0, 214, -214, 1);
    check("C_g1_re", out_re, pack4(201, 205, 209, 213));
    drive(0, 1, 0, 215, -215, 2);
    check("C_flag_once", 64'(flag_cyc.size() - nflag), 64'd1);

    // Frame D: reset at wr_cnt=7 then a fresh frame into bank 0
    for (int k = 0; k < 7; k++) drive(0, 1, 0, 500 + k, -(500 + k), 1);
    drive(1, 0, 0, 0, 0, 0);
    check("D_rst_re", out_re, '0);
    check("D_rst_im", out_im, '0);
    for (int k = 0; k < 16; k++) begin
      drive(0, 1, 0, 300 + k, -(300 + k), 0);
      if (k == 13) check("D_g0_re", out_re, pack4(300, 304, 308, 312));
    end

`ifdef SP_SOF_SYNC_EN
    // Abort a frame at sample 9 with in_sof
    nflag = flag_cyc.size();
    for (int k = 0; k < 9; k++) drive(0, 1, 0, 400 + k, -(400 + k), 0);
    drive(0, 0, 1, 999, -999, 0);
    drive(0, 1, 1, 409, -409, 0);
    for (int k = 10; k < 22; k++) drive(0, 1, 0, 400 + k, -(400 + k), 0);
    drive(0, 1, 0, 422, -422, 0);
    check("SOF_g0_re", out_re, pack4(409, 413, 417, 421));
    check("SOF_flag_once", 64'(flag_cyc.size() - nflag), 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
